mc_price_aggregator: RTL and testbench
======================================

// Module: mc_price_aggregator
// PURPOSE
//  Parametrised multi-core Monte Carlo result aggregator for the option-pricing engine.
//  Collects per-path payoffs from NUM_CORES pricing cores in parallel.
//  Accumulates exactly 2**LOG2_PATHS samples and outputs their floor average as the option price.
//  Adds over the single-core averager: multi-lane merge, an exact sample-count cap, abort, and a busy/core_start handshake.
// PARAMETERS
//  W           12  payoff/price width (unsigned)
//  NUM_CORES   4   number of core result lanes (>=1, may exceed 2**LOG2_PATHS)
//  LOG2_PATHS  3   log2 of paths averaged per run (PATHS = 2**LOG2_PATHS)
// PORTS
//  clk         in   1              clock, rising edge
//  rst_n       in   1              asynchronous, active-low reset
//  start       in   1              begin a run (honoured only in IDLE)
//  abort       in   1              cancel the current run (honoured only in RUN)
//  core_valid  in   NUM_CORES      lane i carries a valid payoff this cycle
//  core_price  in   NUM_CORES*W    lane i payoff at [i*W +: W]
//  core_start  out  1              1-cycle pulse that launches the cores
//  busy        out  1              high while in RUN
//  path_cnt    out  LOG2_PATHS+1   samples accepted in the current/last run
//  price       out  W              average payoff of the last completed run
//  valid       out  1              1-cycle pulse: price is updated
// BEHAVIOUR
//  - Reset values: all outputs 0. Internal: state=IDLE, sum=0, cnt=0.
//  - sum is W+LOG2_PATHS bits wide. It cannot overflow, even when every sample is 2**W-1.
//  - FSM has two states, IDLE and RUN. All outputs are registered.
//  - IDLE: start=1 at an edge causes all of the following at that edge:
//    - sum and cnt are cleared; state goes to RUN.
//    - busy and core_start go to 1. core_start drops to 0 one cycle later.
//    - core_valid is ignored in IDLE, including in the start cycle.
//  - RUN, per cycle:
//    - rem = PATHS - cnt.
//    - Accept the lowest-indexed valid lanes, at most rem of them. Extra valid lanes are dropped silently.
//    - sum += sum of the accepted prices; cnt += number accepted.
//    - start is ignored.
//  - Completion: at the edge where cnt_next == PATHS, all of the following happen together:
//    - price <= sum_next >> LOG2_PATHS (truncation, floor).
//    - valid <= 1 for exactly one cycle.
//    - busy <= 0; state goes to IDLE.
//  - Latency: valid is high the cycle after the final sample is presented.
//  - price holds its value until the next completion. path_cnt holds its value until the next start.
//  - abort in RUN: at that edge, state goes to IDLE and busy goes to 0, with no valid pulse. price is unchanged.
//  - abort in the same cycle as the final sample: abort wins. That sample is not accepted; no valid pulse.
//  - start and abort together in IDLE: start is honoured; abort is ignored.
//  - A new start is accepted in the cycle valid is high, because the state is already IDLE.
//  - Asserting rst_n low mid-run: immediate return to reset values. No partial result is output.
// TESTING (defaults W=12, NUM_CORES=4, LOG2_PATHS=3; lane i price = 10*(i+1) unless stated)
//  1. start; all 4 lanes valid for 2 cycles at price 100
//     -> valid pulses 1 cycle after the 2nd batch; price=100; path_cnt=8; busy low with valid.
//  2. Cap: lanes 0-2 valid for 2 cycles, then all 4 lanes valid
//     -> only lanes 0,1 taken in the 3rd cycle; sum=150; price=18; lanes 2,3 dropped.
//  3. All samples 4095 (0xFFF)
//     -> price=4095; no overflow.
//  4. Abort after 4 samples
//     -> no valid pulse; busy=0; price keeps the previous value.
//     Then restart with 8 samples of 50 -> price=50 (no stale sum).
//  5. core_valid asserted in IDLE and in the start cycle; start pulsed mid-RUN
//     -> all ignored; the count starts at the first RUN cycle.
//     Abort in the same cycle as the final sample -> no valid pulse.
//  6. rst_n asserted mid-run
//     -> all outputs 0 at once. After release, a normal run completes correctly.

Source files
------------

// File: rtl/mc_price_aggregator.sv
// Multi-lane Monte Carlo payoff aggregator: merges per-core payoffs, stops at
// exactly 2**LOG2_PATHS samples and reports their floor average.
module mc_price_lane #(
    parameter int W  = 12,
    parameter int CW = 4,
    parameter int SW = 15
) (
    input  logic          valid,
    input  logic [W-1:0]  price,
    input  logic [CW-1:0] rem,
    input  logic [CW-1:0] taken_in,
    input  logic [SW-1:0] sum_in,
    output logic [CW-1:0] taken_out,
    output logic [SW-1:0] sum_out
);
    logic take;

    // Lower lanes have priority; a lane is taken only while the quota has room.
    assign take      = valid && (taken_in < rem);
    assign taken_out = taken_in + CW'(take);
    assign sum_out   = sum_in + (take ? SW'(price) : '0);
endmodule

module mc_price_aggregator #(
    parameter int W          = 12,
    parameter int NUM_CORES  = 4,
    parameter int LOG2_PATHS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_CORES-1:0]   core_valid,
    input  logic [NUM_CORES*W-1:0] core_price,
    output logic                   core_start,
    output logic                   busy,
    output logic [LOG2_PATHS:0]    path_cnt,
    output logic [W-1:0]           price,
    output logic                   valid
);
    localparam int CW = LOG2_PATHS + 1;
    localparam int SW = W + LOG2_PATHS;
    localparam logic [CW-1:0] PATHS = CW'(2 ** LOG2_PATHS);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  price_q, price_d;
    logic          busy_q, busy_d;
    logic          core_start_q, core_start_d;
    logic          valid_q, valid_d;

    logic [CW-1:0] rem;
    logic [SW-1:0] sum_nx;
    logic [CW-1:0] cnt_nx;
    logic [NUM_CORES:0][CW-1:0] taken_chain;
    logic [NUM_CORES:0][SW-1:0] sum_chain;

    assign rem            = PATHS - cnt_q;
    assign taken_chain[0] = '0;
    assign sum_chain[0]   = '0;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        mc_price_lane #(.W(W), .CW(CW), .SW(SW)) u_lane (
            .valid     (core_valid[i]),
            .price     (core_price[i*W +: W]),
            .rem       (rem),
            .taken_in  (taken_chain[i]),
            .sum_in    (sum_chain[i]),
            .taken_out (taken_chain[i+1]),
            .sum_out   (sum_chain[i+1])
        );
    end

    assign sum_nx = sum_q + sum_chain[NUM_CORES];
    assign cnt_nx = cnt_q + taken_chain[NUM_CORES];

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        cnt_d        = cnt_q;
        price_d      = price_q;
        busy_d       = busy_q;
        core_start_d = 1'b0;
        valid_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = RUN;
                    sum_d        = '0;
                    cnt_d        = '0;
                    busy_d       = 1'b1;
                    core_start_d = 1'b1;
                end
            end
            RUN: begin
                // Abort beats a completing sample: nothing from this cycle is kept.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    sum_d = sum_nx;
                    cnt_d = cnt_nx;
                    if (cnt_nx == PATHS) begin
                        price_d = sum_nx[SW-1:LOG2_PATHS];
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sum_q        <= '0;
            cnt_q        <= '0;
            price_q      <= '0;
            busy_q       <= 1'b0;
            core_start_q <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            cnt_q        <= cnt_d;
            price_q      <= price_d;
            busy_q       <= busy_d;
            core_start_q <= core_start_d;
            valid_q      <= valid_d;
        end
    end

    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign path_cnt   = cnt_q;
    assign price      = price_q;
    assign valid      = valid_q;
endmodule

// File: tb/tb_mc_price_aggregator.sv
// Scoreboard bench: a sample-list model predicts each run's average; a negedge
// monitor checks every output against it.
module tb_mc_price_aggregator;
    localparam int W     = 12;
    localparam int NC    = 4;
    localparam int L     = 3;
    localparam int PATHS = 1 << L;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [NC-1:0]   core_valid = '0;
    logic [NC*W-1:0] core_price = '0;
    logic            core_start, busy, valid;
    logic [L:0]      path_cnt;
    logic [W-1:0]    price;

    mc_price_aggregator #(.W(W), .NUM_CORES(NC), .LOG2_PATHS(L)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .core_valid(core_valid), .core_price(core_price),
        .core_start(core_start), .busy(busy), .path_cnt(path_cnt),
        .price(price), .valid(valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // model state, committed at each rising edge
    bit running = 0;
    bit exp_cs  = 0;
    int exp_price = 0;
    int samples[$];
    int sb[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [NC*W-1:0] pk(input int a, input int b, input int c, input int d);
        logic [NC*W-1:0] r;
        r = {W'(d), W'(c), W'(b), W'(a)};
        return r;
    endfunction

    task automatic cyc(input bit st, input bit ab, input logic [NC-1:0] vm, input logic [NC*W-1:0] pr);
        bit n_run, n_cs, done;
        int nxt[$];
        int s;
        @(negedge clk);
        start = st; abort = ab; core_valid = vm; core_price = pr;
        nxt = samples;
        n_run = running; n_cs = 0; done = 0;
        if (!running) begin
            if (st) begin
                n_run = 1; n_cs = 1;
                nxt.delete();
            end
        end else if (ab) begin
            n_run = 0;
        end else begin
            for (int i = 0; i < NC; i++)
                if (vm[i] && nxt.size() < PATHS) nxt.push_back(int'(pr[i*W +: W]));
            if (nxt.size() == PATHS) begin
                done = 1; n_run = 0;
            end
        end
        @(posedge clk);
        running = n_run;
        exp_cs  = n_cs;
        samples = nxt;
        if (done) begin
            s = 0;
            foreach (nxt[i]) s += nxt[i];
            exp_price = s / PATHS;
            sb.push_back(exp_price);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, '0, '0);
    endtask

    task automatic model_reset();
        running = 0; exp_cs = 0; exp_price = 0;
        samples.delete(); sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_core_start"}, int'(core_start), 0);
        chk({tag, "_path_cnt"}, int'(path_cnt), 0);
        chk({tag, "_price"}, int'(price), 0);
        chk({tag, "_valid"}, int'(valid), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) begin
                if (sb.size() == 0) chk("unexpected_valid", 1, 0);
                else chk("price", int'(price), sb.pop_front());
            end else begin
                if (sb.size() != 0) begin
                    chk("missing_valid", 0, 1);
                    void'(sb.pop_front());
                end
                chk("price_hold", int'(price), exp_price);
            end
            chk("busy", int'(busy), int'(running));
            chk("core_start", int'(core_start), int'(exp_cs));
            chk("path_cnt", int'(path_cnt), samples.size());
        end
    end

    initial begin
        #1 chk_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: two full batches at 100
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'hF, pk(100, 100, 100, 100));
        cyc(0, 0, 4'hF, pk(100, 100, 100, 100));
        idle(2);

        // 2: quota cap drops lanes 2,3 in the third cycle -> 150/8 = 18
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'h7, pk(10, 20, 30, 40));
        cyc(0, 0, 4'h7, pk(10, 20, 30, 40));
        cyc(0, 0, 4'hF, pk(10, 20, 30, 40));
        idle(2);

        // 3: all-max samples
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'hF, pk(4095, 4095, 4095, 4095));
        cyc(0, 0, 4'hF, pk(4095, 4095, 4095, 4095));
        idle(2);

        // 4: abort after 4 samples, then a clean run at 50
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'hF, pk(10, 20, 30, 40));
        cyc(0, 1, '0, '0);
        idle(2);
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'hF, pk(50, 50, 50, 50));
        cyc(0, 0, 4'hF, pk(50, 50, 50, 50));
        idle(1);

        // 5: valid in IDLE and start cycle, start mid-run, abort on final sample
        cyc(0, 0, 4'hF, pk(10, 20, 30, 40));
        cyc(1, 1, 4'hF, pk(10, 20, 30, 40));
        cyc(1, 0, 4'hF, pk(10, 20, 30, 40));
        cyc(1, 0, 4'h7, pk(10, 20, 30, 40));
        cyc(0, 1, 4'h1, pk(10, 20, 30, 40));
        idle(2);

        // new start in the valid cycle
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'hF, pk(1, 2, 3, 4));
        cyc(0, 0, 4'hF, pk(5, 6, 7, 8));
        cyc(1, 0, 4'hF, pk(9, 9, 9, 9));
        cyc(0, 0, 4'hF, pk(9, 9, 9, 9));
        cyc(0, 0, 4'hF, pk(7, 7, 7, 7));
        idle(1);

        // 6: asynchronous reset mid-run
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'hF, pk(10, 20, 30, 40));
        #2 rst_n = 1'b0;
        #1 chk_zero("midrun_reset");
        model_reset();
        start = 0; abort = 0; core_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 0, '0, '0);
        cyc(0, 0, 4'hF, pk(10, 20, 30, 40));
        cyc(0, 0, 4'hF, pk(10, 20, 30, 40));
        idle(2);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [NC*W-1:0] pr;
            pr = (NC*W)'({$urandom(), $urandom()});
            if ($urandom_range(0, 9) == 0) pr = {NC{12'hFFF}};
            cyc($urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                NC'($urandom()), pr);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
